// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN I/O front end.
package cnn_pkg;

    localparam int WORD_W    = 32;
    localparam int IMG_DEPTH = 48;
    localparam int KER_DEPTH = 27;
    localparam int WGT_DEPTH = 4;
    localparam int OUT_WORDS = 4;

    // A frame is IMG_DEPTH beats long, so the image index width also covers beat numbers.
    localparam int BEAT_W = $clog2(IMG_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_CORE,
        EMIT
    } state_t;

endpackage

// File: rtl/cnn_io_frontend_if.sv
// Host-side frame bus: input beats towards the front end, result words back out.
interface cnn_io_frontend_if;
    import cnn_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] Img;
    logic [WORD_W-1:0] Kernel;
    logic [WORD_W-1:0] Weight;
    logic [1:0]        Opt;
    logic              out_valid;
    logic [WORD_W-1:0] out;

    // Host side drives frames and receives results.
    modport master (
        output in_valid, Img, Kernel, Weight, Opt,
        input  out_valid, out
    );

    // Front end receives frames and drives results.
    modport slave (
        input  in_valid, Img, Kernel, Weight, Opt,
        output out_valid, out
    );

endinterface

// File: rtl/cnn_out_serializer.sv
// Loads one OUT_WORDS-wide result and plays it out one word per cycle, word0 first.
// out is held at zero whenever out_valid is low.
module cnn_out_serializer
    import cnn_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [OUT_WORDS*WORD_W-1:0] data,
    output logic                        out_valid,
    output logic [WORD_W-1:0]           out,
    output logic                        last
);

    localparam int CNT_W = $clog2(OUT_WORDS);

    logic [(OUT_WORDS-1)*WORD_W-1:0] shreg;
    logic [CNT_W-1:0]                remain;

    // Word shifter: first word goes straight to out on load, the rest drain from shreg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            shreg     <= '0;
            remain    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out       <= data[WORD_W-1:0];
            shreg     <= data[OUT_WORDS*WORD_W-1:WORD_W];
            remain    <= CNT_W'(OUT_WORDS - 1);
        end else if (out_valid && (remain != '0)) begin
            out    <= shreg[WORD_W-1:0];
            shreg  <= {{WORD_W{1'b0}}, shreg[(OUT_WORDS-1)*WORD_W-1:WORD_W]};
            remain <= remain - 1'b1;
        end else begin
            out_valid <= 1'b0;
            out       <= '0;
        end
    end

    // High during the final word so the controller can leave EMIT on the same edge.
    assign last = out_valid && (remain == '0);

endmodule

// File: rtl/cnn_io_frontend.sv
// CNN I/O front end: captures a 48-beat frame into image/kernel/weight buffers,
// hands off to the core, waits (bounded) for its 128-bit result and serialises it.
module cnn_io_frontend
    import cnn_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cnn_io_frontend_if.slave            bus,
    input  logic [5:0]                  img_idx,
    output logic [WORD_W-1:0]           img_rd,
    input  logic [4:0]                  ker_idx,
    output logic [WORD_W-1:0]           ker_rd,
    input  logic [1:0]                  wgt_idx,
    output logic [WORD_W-1:0]           wgt_rd,
    output logic [1:0]                  opt_q,
    output logic                        load_done,
    input  logic                        res_valid,
    input  logic [OUT_WORDS*WORD_W-1:0] res_data,
    output logic                        res_ready,
    output logic                        proto_err
);

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [31:0]         wait_cnt;
    logic                frame_beat;
    logic [BEAT_W-1:0]   beat_idx;
    logic                ser_load;
    logic                ser_last;

    logic [WORD_W-1:0] img_buf [IMG_DEPTH];
    logic [WORD_W-1:0] ker_buf [KER_DEPTH];
    logic [WORD_W-1:0] wgt_buf [WGT_DEPTH];

    // Decide whether this cycle carries a frame beat and which buffer slot it targets.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
        frame_beat = 1'b0;
        beat_idx   = '0;
        if (bus.in_valid) begin
            if (state == IDLE) begin
                frame_beat = 1'b1;
            end else if (state == LOAD) begin
                frame_beat = 1'b1;
                beat_idx   = beat_cnt;
            end
        end
    end

    // Buffer writes; kernel and weight buffers only take the leading beats of a frame.
    // NOTE: the buffers deliberately have no reset - their contents are only meaningful once written, and a reset would stop them mapping to plain RAM.
    always_ff @(posedge clk) begin
        if (frame_beat) begin
            img_buf[beat_idx] <= bus.Img;
            if (beat_idx < BEAT_W'(KER_DEPTH)) ker_buf[beat_idx[4:0]] <= bus.Kernel;
            if (beat_idx < BEAT_W'(WGT_DEPTH)) wgt_buf[beat_idx[1:0]] <= bus.Weight;
        end
    end

    // Core read ports; indices past the buffer depth read as zero.
    assign img_rd = (img_idx < 6'(IMG_DEPTH)) ? img_buf[img_idx] : '0;
    assign ker_rd = (ker_idx < 5'(KER_DEPTH)) ? ker_buf[ker_idx] : '0;
    assign wgt_rd = wgt_buf[wgt_idx];  // 2-bit index spans exactly the four weight slots

    assign ser_load = (state == WAIT_CORE) && res_valid && res_ready;

    // Frame controller: load, core hand-off with timeout, emission, sticky error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            load_done <= 1'b0;
            res_ready <= 1'b0;
            proto_err <= 1'b0;
            opt_q     <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opt_q    <= bus.Opt;
                        beat_cnt <= BEAT_W'(1);
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!bus.in_valid) begin
                        // Frame ended early: discard it.
                        proto_err <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= IDLE;
                    end else if (beat_cnt == BEAT_W'(IMG_DEPTH - 1)) begin
                        load_done <= 1'b1;
                        res_ready <= 1'b1;
                        wait_cnt  <= '0;
                        beat_cnt  <= '0;
                        state     <= WAIT_CORE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                WAIT_CORE: begin
                    if (bus.in_valid) proto_err <= 1'b1;
                    if (res_valid && res_ready) begin
                        res_ready <= 1'b0;
                        state     <= EMIT;
                    end else if (wait_cnt == 32'(TIMEOUT - 1)) begin
                        proto_err <= 1'b1;
                        res_ready <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.in_valid) proto_err <= 1'b1;
                    if (ser_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    cnn_out_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .data      (res_data),
        .out_valid (bus.out_valid),
        .out       (bus.out),
        .last      (ser_last)
    );

endmodule

// File: tb/tb_cnn_io_frontend.sv
// Directed bench for cnn_io_frontend: full/short frames, result emission,
// timeout, reset during emission and stray input beats.
module tb_cnn_io_frontend;

    logic         clk;
    logic         rst_n;
    logic [5:0]   img_idx;
    logic [31:0]  img_rd;
    logic [4:0]   ker_idx;
    logic [31:0]  ker_rd;
    logic [1:0]   wgt_idx;
    logic [31:0]  wgt_rd;
    logic [1:0]   opt_q;
    logic         load_done;
    logic         res_valid;
    logic [127:0] res_data;
    logic         res_ready;
    logic         proto_err;

    int n_checks = 0;
    int n_pass   = 0;
    int zero_viol = 0;
    int ld_seen   = 0;
    int ov_seen   = 0;

    cnn_io_frontend_if bus ();

    cnn_io_frontend #(.TIMEOUT(1000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .img_idx   (img_idx),
        .img_rd    (img_rd),
        .ker_idx   (ker_idx),
        .ker_rd    (ker_rd),
        .wgt_idx   (wgt_idx),
        .wgt_rd    (wgt_rd),
        .opt_q     (opt_q),
        .load_done (load_done),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (!bus.out_valid && bus.out != 32'h0) zero_viol++;
        if (load_done) ld_seen++;
        if (bus.out_valid) ov_seen++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the last beat was sampled.
    task automatic drive_frame(input int nbeats, input logic [1:0] opt,
                               input logic [31:0] ib, input logic [31:0] kb, input logic [31:0] wb);
        for (int b = 0; b < nbeats; b++) begin
            bus.in_valid = 1'b1;
            bus.Img      = ib + 32'(b);
            bus.Kernel   = kb + 32'(b);
            bus.Weight   = wb + 32'(b);
            bus.Opt      = (b == 0) ? opt : ~opt;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.Img      = '0;
        bus.Kernel   = '0;
        bus.Weight   = '0;
        bus.Opt      = '0;
    endtask

    task automatic rd_img(input string tag, input logic [5:0] i, input logic [31:0] exp);
        img_idx = i;
        #1 check(tag, img_rd, exp);
    endtask

    task automatic rd_ker(input string tag, input logic [4:0] i, input logic [31:0] exp);
        ker_idx = i;
        #1 check(tag, ker_rd, exp);
    endtask

    task automatic rd_wgt(input string tag, input logic [1:0] i, input logic [31:0] exp);
        wgt_idx = i;
        #1 check(tag, wgt_rd, exp);
    endtask

    // Handshake a result and check the four emitted words; optionally inject stray beats mid-EMIT.
    task automatic emit(input string tag, input logic [127:0] data,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input bit inject);
        logic [31:0] exp_w [4];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        res_valid = 1'b1;
        res_data  = data;
        @(negedge clk);
        res_valid = 1'b0;
        check($sformatf("%s_ready_low", tag), res_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_ov%0d", tag, k), bus.out_valid, 1'b1);
            check($sformatf("%s_w%0d", tag, k), bus.out, exp_w[k]);
            if (inject && k == 1) begin
                bus.in_valid = 1'b1;
                bus.Img      = 32'hFFFF_FFFF;
                bus.Kernel   = 32'hEEEE_EEEE;
                bus.Weight   = 32'hDDDD_DDDD;
            end
            if (inject && k == 3) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check($sformatf("%s_ov_end", tag), bus.out_valid, 1'b0);
        check($sformatf("%s_out_end", tag), bus.out, 32'h0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ld_before;
        int ov_before;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.Img      = '0;
        bus.Kernel   = '0;
        bus.Weight   = '0;
        bus.Opt      = '0;
        img_idx      = '0;
        ker_idx      = '0;
        wgt_idx      = '0;
        res_valid    = 1'b0;
        res_data     = '0;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out", bus.out, 32'h0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_res_ready", res_ready, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_opt_q", opt_q, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame A: Opt=2, Img=i, Kernel=0x100+i, Weight=0x200+i
        drive_frame(48, 2'd2, 32'h0, 32'h100, 32'h200);
        check("A_load_done", load_done, 1'b1);
        check("A_res_ready", res_ready, 1'b1);
        check("A_opt_q", opt_q, 2'd2);
        rd_img("A_img47", 6'd47, 32'd47);
        rd_img("A_img0", 6'd0, 32'd0);
        rd_img("A_img50_oor", 6'd50, 32'h0);
        rd_ker("A_ker26", 5'd26, 32'h11A);
        rd_ker("A_ker0", 5'd0, 32'h100);
        rd_ker("A_ker27_oor", 5'd27, 32'h0);
        rd_wgt("A_wgt3", 2'd3, 32'h203);
        rd_wgt("A_wgt0", 2'd0, 32'h200);
        @(negedge clk);
        check("A_load_done_pulse", load_done, 1'b0);
        check("A_no_err", proto_err, 1'b0);
        emit("A", 128'h40400000_40000000_3F800000_00000000,
             32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);

        // Frame B starts in the first cycle after EMIT ends
        drive_frame(48, 2'd1, 32'h1000, 32'h2000, 32'h3000);
        check("B_load_done", load_done, 1'b1);
        check("B_opt_q", opt_q, 2'd1);
        rd_img("B_img5", 6'd5, 32'h1005);
        check("B_no_err", proto_err, 1'b0);
        @(negedge clk);
        emit("B", 128'h12345678_DEADBEEF_3F000000_C0A00000,
             32'hC0A00000, 32'h3F000000, 32'hDEADBEEF, 32'h12345678, 1'b1);
        check("B_inject_err", proto_err, 1'b1);
        rd_img("B_img0_kept", 6'd0, 32'h1000);
        rd_img("B_img47_kept", 6'd47, 32'h102F);
        rd_ker("B_ker0_kept", 5'd0, 32'h2000);
        rd_wgt("B_wgt0_kept", 2'd0, 32'h3000);
        @(negedge clk);

        // Short frame then a normal frame
        pulse_reset();
        check("S_err_cleared", proto_err, 1'b0);
        ld_before = ld_seen;
        drive_frame(20, 2'd0, 32'h900, 32'h900, 32'h900);
        @(negedge clk);
        check("S_proto_err", proto_err, 1'b1);
        check("S_res_ready", res_ready, 1'b0);
        @(negedge clk);
        check("S_no_load_done", ld_seen, ld_before);
        drive_frame(48, 2'd3, 32'h500, 32'h600, 32'h700);
        check("C_load_done", load_done, 1'b1);
        check("C_opt_q", opt_q, 2'd3);
        rd_img("C_img0", 6'd0, 32'h500);
        rd_img("C_img19", 6'd19, 32'h513);
        @(negedge clk);
        emit("C", 128'h0000000A_0000000B_0000000C_0000000D,
             32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A, 1'b0);
        check("C_err_sticky", proto_err, 1'b1);

        // Timeout: no core response
        pulse_reset();
        ov_before = ov_seen;
        drive_frame(48, 2'd1, 32'h10, 32'h20, 32'h30);
        check("T_load_done", load_done, 1'b1);
        repeat (995) @(negedge clk);
        check("T_err_not_yet", proto_err, 1'b0);
        check("T_still_waiting", res_ready, 1'b1);
        repeat (5) @(negedge clk);
        check("T_proto_err", proto_err, 1'b1);
        check("T_idle_ready_low", res_ready, 1'b0);
        res_valid = 1'b1;
        res_data  = 128'hFFFF;
        repeat (3) @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        check("T_no_out_valid", ov_seen, ov_before);

        // Reset while word1 is on the output
        pulse_reset();
        drive_frame(48, 2'd2, 32'h40, 32'h50, 32'h60);
        check("E_load_done", load_done, 1'b1);
        res_valid = 1'b1;
        res_data  = 128'h44444444_33333333_22222222_11111111;
        @(negedge clk);
        res_valid = 1'b0;
        check("E_w0", bus.out, 32'h11111111);
        @(negedge clk);
        check("E_w1", bus.out, 32'h22222222);
        rst_n = 1'b0;
        #1;
        check("E_rst_ov", bus.out_valid, 1'b0);
        check("E_rst_out", bus.out, 32'h0);
        check("E_rst_opt", opt_q, 2'd0);
        check("E_rst_ready", res_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("E_idle_after_rst", bus.out_valid, 1'b0);
        drive_frame(48, 2'd1, 32'h7000, 32'h7100, 32'h7200);
        check("F_load_done", load_done, 1'b1);
        rd_img("F_img0", 6'd0, 32'h7000);
        rd_ker("F_ker26", 5'd26, 32'h711A);
        @(negedge clk);
        emit("F", 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A,
             32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D, 1'b0);
        check("F_no_err", proto_err, 1'b0);

        @(negedge clk);
        check("out_zero_when_idle", zero_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_io_frontend.md
CNN_IO_FRONTEND -- requirements
Module: cnn_io_frontend

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  frame beat qualifier, high for exactly 48 consecutive cycles per frame.
REQ-004 SHALL have ports: Img  input  32  beats 0-47; Kernel  input  32  beats 0-26; Weight  input  32  beats 0-3 (IEEE-754 single).
REQ-005 SHALL have port: Opt  input  2  valid on beat 0 only.
REQ-006 SHALL have ports: out_valid  output  1  result qualifier; out  output  32  result word.
REQ-007 SHALL have core-side ports: img_idx input 6, img_rd output 32; ker_idx input 5, ker_rd output 32; wgt_idx input 2, wgt_rd output 32; opt_q output 2.
REQ-008 SHALL have core-side ports: load_done output 1 (one-cycle pulse), res_valid input 1, res_data input 128 (word0 = [31:0]), res_ready output 1.
REQ-009 SHALL have status port: proto_err output 1, sticky protocol-violation flag.
REQ-010 SHALL use parameter: TIMEOUT, default 1000, maximum cycles from last input beat to first out_valid.

Function
REQ-011 SHALL implement states IDLE, LOAD, WAIT_CORE, EMIT.
REQ-012 IDLE -> LOAD on in_valid=1; that beat is beat 0 and Opt, Img[0], Kernel[0], Weight[0] SHALL be stored.
REQ-013 LOAD: beat n stores Img into img buffer[n]; Kernel stored only for n<27; Weight only for n<4; Opt ignored after beat 0.
REQ-014 After beat 47, SHALL enter WAIT_CORE and pulse load_done in the cycle following beat 47.
REQ-015 Short frame (in_valid low before beat 47) SHALL set proto_err, drop load_done, return to IDLE.
REQ-016 Beats beyond 47 (in_valid still high in WAIT_CORE) SHALL be ignored and set proto_err.
REQ-017 Buffer read ports SHALL be combinational from index; index beyond depth SHALL read 0.
REQ-018 res_ready SHALL be high only in WAIT_CORE; res_valid in other states SHALL be ignored.
REQ-019 On res_valid&&res_ready, SHALL latch res_data and enter EMIT; out_valid SHALL rise the next cycle.
REQ-020 EMIT: out_valid high exactly 4 consecutive cycles, out = word0..word3 in order, then return to IDLE.
REQ-021 out SHALL be 0 in every cycle out_valid is 0.
REQ-022 in_valid in WAIT_CORE or EMIT SHALL be ignored (not stored) and set proto_err; EMIT continues unaffected.
REQ-023 A cycle counter SHALL run in WAIT_CORE; reaching TIMEOUT SHALL set proto_err and return to IDLE without output.
REQ-024 A new frame SHALL be accepted in the first cycle after EMIT ends.
REQ-025 Buffers SHALL retain contents until overwritten by a later frame.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid=0, out=0, load_done=0, res_ready=0, proto_err=0, opt_q=0, counters=0.
REQ-027 Buffer contents need not be reset.
REQ-028 Reset mid-LOAD or mid-EMIT SHALL abort the frame; after release, first in_valid is beat 0.

Structure
REQ-029 Shared package cnn_pkg SHALL hold IMG_DEPTH=48, KER_DEPTH=27, WGT_DEPTH=4, OUT_WORDS=4, and the state enumeration.
REQ-030 Output sequencing SHALL be a sub-module cnn_out_serializer (128-bit load, 4-beat shift, out zeroing).

Verification
REQ-031 Full frame, Opt=2, Img[i]=i, Kernel[i]=0x100+i, Weight[i]=0x200+i -> load_done one cycle after beat 47; img_rd(47)=47, ker_rd(26)=0x11A, wgt_rd(3)=0x203, opt_q=2.
REQ-032 res_data={0x40400000,0x40000000,0x3F800000,0x00000000} -> out 0x00000000,0x3F800000,0x40000000,0x40400000 on 4 consecutive cycles, then out_valid=0, out=0.
REQ-033 in_valid dropped after 20 beats -> proto_err=1, no load_done, next full frame processed normally.
REQ-034 No res_valid for 1000 cycles after load_done -> proto_err=1, state IDLE, out_valid never asserted.
REQ-035 rst_n pulsed low during EMIT word1 -> out_valid=0, out=0 immediately; next frame correct.
REQ-036 in_valid=1 during EMIT -> proto_err=1, all 4 words still emitted, buffers unchanged.
